// File: rtl/sys_ctrl_tx_framer.sv
// sys_ctrl_tx_framer: queues read/ALU messages and serialises them low byte first to the UART TX.
// SYS_TX_TOGGLE_EN: Tx_Data_valid_o toggles once per byte instead of pulsing.
module sys_ctrl_tx_framer #(
   parameter int WIDTH     = 8,
   parameter int RES_BYTES = 2,
   parameter int DEPTH     = 4,
   parameter int BUSY_TO   = 15
) (
   input  logic                       CLK_i,
   input  logic                       Reset_i,
   input  logic [WIDTH-1:0]           RdData_i,
   input  logic                       Rd_valid_i,
   input  logic [RES_BYTES*WIDTH-1:0] ALU_out_i,
   input  logic                       ALU_out_valid_i,
   input  logic [3:0]                 ALU_FUN_i,
   input  logic                       Busy_i,
   output logic [WIDTH-1:0]           Tx_Data_o,
   output logic                       Tx_Data_valid_o,
   output logic                       Full_o,
   output logic                       Drop_o
);
   localparam int PW = RES_BYTES*WIDTH;
   localparam int NW = $clog2(RES_BYTES+1);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(BUSY_TO+1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] pay_mem [DEPTH];
   logic [NW-1:0] nb_mem [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q, cnt_d;
   logic [PW-1:0] shift_q, shift_d, in_pay;
   logic [NW-1:0] bytes_q, bytes_d, in_nb;
   logic [TW-1:0] timer_q, timer_d;
   logic [WIDTH-1:0] tx_d;
   logic txv_d, push, pop, accept, drop_d, strobe, arith;
   // An ALU result wins over a simultaneous read; the read is reported as dropped.
   always_comb begin
      arith  = ALU_out_valid_i && ALU_FUN_i[3:2] == 2'b00;
      in_pay = arith ? ALU_out_i : ALU_out_valid_i ? PW'(ALU_out_i[WIDTH-1:0]) : PW'(RdData_i);
      in_nb  = arith ? NW'(RES_BYTES) : NW'(1);
      push   = Rd_valid_i | ALU_out_valid_i;
      pop    = state_q == LOAD;
      accept = push && (cnt_q != FULL_CNT || pop);
      drop_d = (Rd_valid_i && ALU_out_valid_i) || (push && !accept);
      cnt_d  = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
   end
   always_ff @(posedge CLK_i or posedge Reset_i)
      if (Reset_i) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         Full_o <= 1'b0;
         Drop_o <= 1'b0;
      end else begin
         wr_q   <= wr_q + AW'(accept);
         rd_q   <= rd_q + AW'(pop);
         cnt_q  <= cnt_d;
         Full_o <= cnt_d == FULL_CNT;
         Drop_o <= drop_d;
      end
   always_ff @(posedge CLK_i)
      if (accept) begin
         pay_mem[wr_q] <= in_pay;
         nb_mem[wr_q]  <= in_nb;
      end
   always_ff @(posedge CLK_i or posedge Reset_i)
      if (Reset_i) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (|cnt_q) state_d = LOAD;
         LOAD:      state_d = SEND;
         SEND:      if (!Busy_i) state_d = WAIT_BUSY;
         WAIT_BUSY: if (Busy_i) state_d = WAIT_DONE;
                    else if (timer_q == TW'(BUSY_TO-1)) state_d = SEND;
         WAIT_DONE: if (!Busy_i) state_d = bytes_q == NW'(1) ? IDLE : SEND;
         default:   state_d = IDLE;
      endcase
   end
   always_comb begin
      strobe  = state_q == SEND && !Busy_i;
      shift_d = shift_q;
      bytes_d = bytes_q;
      timer_d = timer_q;
      tx_d    = Tx_Data_o;
      if (pop) begin
         shift_d = pay_mem[rd_q];
         bytes_d = nb_mem[rd_q];
      end
      if (strobe) begin
         tx_d    = shift_q[WIDTH-1:0];
         timer_d = '0;
      end
      if (state_q == WAIT_BUSY) timer_d = timer_q + 1'b1;
      if (state_q == WAIT_DONE && !Busy_i) begin
         shift_d = shift_q >> WIDTH;
         bytes_d = bytes_q - 1'b1;
      end
`ifdef SYS_TX_TOGGLE_EN
      txv_d = Tx_Data_valid_o ^ strobe;
`else
      txv_d = strobe;
`endif
   end
   always_ff @(posedge CLK_i or posedge Reset_i)
      if (Reset_i) begin
         shift_q         <= '0;
         bytes_q         <= '0;
         timer_q         <= '0;
         Tx_Data_o       <= '0;
         Tx_Data_valid_o <= 1'b0;
      end else begin
         shift_q         <= shift_d;
         bytes_q         <= bytes_d;
         timer_q         <= timer_d;
         Tx_Data_o       <= tx_d;
         Tx_Data_valid_o <= txv_d;
      end
endmodule

// File: tb/tb_sys_ctrl_tx_framer.sv
// tb_sys_ctrl_tx_framer: directed bench with a message-level byte-stream model and a UART TX responder.
`timescale 1ns/1ps
module tb_sys_ctrl_tx_framer;
   localparam int W = 8, RB = 2, D = 4, TO = 15;
   logic clk = 1'b0, rst = 1'b1;
   logic [W-1:0] rd_data = '0, tx;
   logic [RB*W-1:0] alu = '0;
   logic [3:0] fun = '0;
   logic rd_v = 1'b0, alu_v = 1'b0, busy = 1'b0, txv, full, drop;
   int vec = 0, errs = 0, cyc = 0, push_cyc = 0, occ = 0;
   int nstb = 0, left = 0, bcnt = 0, busy_len = 3, mode = 0, n0;
   logic exp_drop = 1'b0, rep = 1'b0, prev_v = 1'b0, stb;
   logic [W-1:0] last_b = '0;
   logic [W-1:0] expq[$];
   int nbq[$];
   int stbq[$];
   logic [W-1:0] stb_data[$];

   sys_ctrl_tx_framer #(.WIDTH(W), .RES_BYTES(RB), .DEPTH(D), .BUSY_TO(TO)) dut (
      .CLK_i(clk), .Reset_i(rst), .RdData_i(rd_data), .Rd_valid_i(rd_v),
      .ALU_out_i(alu), .ALU_out_valid_i(alu_v), .ALU_FUN_i(fun), .Busy_i(busy),
      .Tx_Data_o(tx), .Tx_Data_valid_o(txv), .Full_o(full), .Drop_o(drop));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Message model: sampled on the same edge as the DUT, expands messages into bytes.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         expq.delete();
         nbq.delete();
         occ = 0;
         exp_drop = 1'b0;
      end else begin
         exp_drop = rd_v && alu_v;
         if (rd_v || alu_v) begin
            if (occ == D) exp_drop = 1'b1;
            else begin
               occ++;
               push_cyc = cyc;
               if (alu_v && fun[3:2] == 2'b00) begin
                  for (int i = 0; i < RB; i++) expq.push_back(W'((alu >> (W*i)) & 'hFF));
                  nbq.push_back(RB);
               end else begin
                  expq.push_back(alu_v ? alu[W-1:0] : rd_data);
                  nbq.push_back(1);
               end
            end
         end
      end
   end

   // Compare process and transmitter responder (mode 0: busy for busy_len cycles per byte, 1: never busy).
   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0;
         bcnt = 0;
         prev_v = 1'b0;
         rep = 1'b0;
         left = 0;
         check("rst_tx", 32'(tx), 0);
         check("rst_txv", 32'(txv), 0);
         check("rst_full", 32'(full), 0);
         check("rst_drop", 32'(drop), 0);
      end else begin
         check("drop", 32'(drop), 32'(exp_drop));
         if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) busy = 1'b0;
         end
`ifdef SYS_TX_TOGGLE_EN
         stb = txv != prev_v;
`else
         stb = txv;
`endif
         prev_v = txv;
         if (stb) begin
            nstb++;
            stbq.push_back(cyc);
            stb_data.push_back(tx);
            if (rep) check("reissue", 32'(tx), 32'(last_b));
            else if (expq.size() == 0) check("unexpected_strobe", 32'(tx), 32'hFFFF_FFFF);
            else begin
               if (left == 0) begin
                  left = nbq.pop_front();
                  occ--;
               end
               left--;
               last_b = expq.pop_front();
               check("byte", 32'(tx), 32'(last_b));
            end
            rep = mode == 1;
            if (mode == 0) begin
               busy = 1'b1;
               bcnt = busy_len;
            end
         end
      end
   end

   task automatic pulse(input logic rv, input logic [W-1:0] rd, input logic av,
                        input logic [RB*W-1:0] a, input logic [3:0] f);
      rd_v = rv; rd_data = rd; alu_v = av; alu = a; fun = f;
      @(negedge clk);
      rd_v = 1'b0; alu_v = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      // Read: single byte, strobe 3 cycles after the sampling edge
      n0 = nstb;
      pulse(1'b1, 8'hA5, 1'b0, '0, 4'h0);
      repeat (30) @(negedge clk);
      check("rd_count", nstb - n0, 1);
      if (nstb > n0) begin
         check("rd_latency", stbq[n0] - push_cyc, 3);
         check("rd_data", 32'(stb_data[n0]), 32'hA5);
      end
      // Arithmetic: two bytes, low first, 10-cycle busy per byte
      busy_len = 10;
      n0 = nstb;
      pulse(1'b0, '0, 1'b1, 16'h1234, 4'b0010);
      repeat (50) @(negedge clk);
      check("arith_count", nstb - n0, 2);
      if (nstb >= n0 + 2) begin
         check("arith_b0", 32'(stb_data[n0]), 32'h34);
         check("arith_b1", 32'(stb_data[n0+1]), 32'h12);
         check("arith_gap", stbq[n0+1] - stbq[n0], 12);
      end
      // Logic op: only the low byte
      busy_len = 3;
      n0 = nstb;
      pulse(1'b0, '0, 1'b1, 16'h00F0, 4'b0100);
      repeat (30) @(negedge clk);
      check("logic_count", nstb - n0, 1);
      if (nstb > n0) check("logic_data", 32'(stb_data[n0]), 32'hF0);
      // Overflow: transmitter held busy on an earlier byte while five reads arrive
      busy_len = 40;
      n0 = nstb;
      pulse(1'b1, 8'h11, 1'b0, '0, 4'h0);
      repeat (6) @(negedge clk);
      pulse(1'b1, 8'h01, 1'b0, '0, 4'h0);
      pulse(1'b1, 8'h02, 1'b0, '0, 4'h0);
      pulse(1'b1, 8'h03, 1'b0, '0, 4'h0);
      check("ovf_full3", 32'(full), 0);
      pulse(1'b1, 8'h04, 1'b0, '0, 4'h0);
      check("ovf_full4", 32'(full), 1);
      pulse(1'b1, 8'h05, 1'b0, '0, 4'h0);
      check("ovf_drop5", 32'(drop), 1);
      check("ovf_full5", 32'(full), 1);
      busy_len = 3;
      repeat (100) @(negedge clk);
      check("ovf_count", nstb - n0, 5);
      check("ovf_full_end", 32'(full), 0);
      for (int i = 1; i <= 4; i++)
         if (nstb > n0 + i) check("ovf_order", 32'(stb_data[n0+i]), i);
      // Timeout: busy never rises, byte re-issued every TO+1 cycles
      mode = 1;
      n0 = nstb;
      pulse(1'b1, 8'h5A, 1'b0, '0, 4'h0);
      repeat (36) @(negedge clk);
      check("to_count", nstb - n0, 3);
      if (nstb >= n0 + 2) check("to_gap", stbq[n0+1] - stbq[n0], TO + 1);
      mode = 0;
      repeat (30) @(negedge clk);
      check("to_count_end", nstb - n0, 4);
      if (nstb >= n0 + 4) check("to_data", 32'(stb_data[n0+3]), 32'h5A);
      // Collision: ALU message kept, read dropped
      n0 = nstb;
      pulse(1'b1, 8'h77, 1'b1, 16'hBEEF, 4'b0001);
      check("col_drop", 32'(drop), 1);
      @(negedge clk);
      check("col_drop_end", 32'(drop), 0);
      repeat (40) @(negedge clk);
      check("col_count", nstb - n0, 2);
      if (nstb >= n0 + 2) begin
         check("col_b0", 32'(stb_data[n0]), 32'hEF);
         check("col_b1", 32'(stb_data[n0+1]), 32'hBE);
      end
      // Reset in the middle of an arithmetic message
      busy_len = 10;
      n0 = nstb;
      pulse(1'b0, '0, 1'b1, 16'hABCD, 4'b0000);
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", 32'(tx), 0);
      check("mid_rst_txv", 32'(txv), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_rst_count", nstb - n0, 1);
      check("mid_rst_tx_hold", 32'(tx), 0);
`ifdef SYS_TX_TOGGLE_EN
      busy_len = 3;
      check("tog_0", 32'(txv), 0);
      pulse(1'b1, 8'h21, 1'b0, '0, 4'h0);
      repeat (15) @(negedge clk);
      check("tog_1", 32'(txv), 1);
      pulse(1'b1, 8'h22, 1'b0, '0, 4'h0);
      repeat (15) @(negedge clk);
      check("tog_2", 32'(txv), 0);
      pulse(1'b1, 8'h23, 1'b0, '0, 4'h0);
      repeat (15) @(negedge clk);
      check("tog_3", 32'(txv), 1);
`endif
      check("drained", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
